// File: rtl/floating_division.sv
// Iterative IEEE-754 single-precision divider (result = A / B) with denormal flush to zero.
// Define FLOAT_DIV_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the quotient truncates.
module floating_division #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [31:0] DEFAULT_NAN    = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        infinity,
    output logic        zero,
    output logic        nan,
    output logic        div_by_zero
);
    localparam int unsigned N = 26 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {StIdle, StSpecial, StDivide, StNorm} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [3:0]  spec_flg_q, spec_flg_d;  // {infinity, zero, nan, div_by_zero}
    logic [31:0] result_q, result_d;
    logic [3:0]  flg_q, flg_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic sign;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_zero = (a_q[30:23] == 8'h00);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_zero = (b_q[30:23] == 8'h00);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    end

    // Restoring division: the partial remainder always stays below the divisor before its shift.
    logic [23:0] divisor;
    logic [24:0] rem_step;
    logic [25:0] quo_step;

    always_comb begin
        divisor  = {1'b1, b_q[22:0]};
        rem_step = rem_q;
        quo_step = quo_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (rem_step >= {1'b0, divisor}) begin
                rem_step = (rem_step - {1'b0, divisor}) << 1;
                quo_step = {quo_step[24:0], 1'b1};
            end else begin
                rem_step = rem_step << 1;
                quo_step = {quo_step[24:0], 1'b0};
            end
        end
    end

    logic signed [9:0] exp_n;
    logic [22:0]       mant;
    logic [31:0]       norm_res;
    logic [3:0]        norm_flg;
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
    logic              guard, sticky;
    logic [23:0]       mant_r;
`else
    logic              unused_quo_lsb;
    assign unused_quo_lsb = quo_q[0];
`endif

    always_comb begin
        exp_n = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        if (quo_q[25]) begin
            mant = quo_q[24:2];
        end else begin
            mant  = quo_q[23:1];
            exp_n = exp_n - 10'sd1;
        end
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
        guard  = quo_q[25] ? quo_q[1] : quo_q[0];
        sticky = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
        mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        mant   = mant_r[22:0];
        if (mant_r[23]) begin
            exp_n = exp_n + 10'sd1;
        end
`endif
        if (exp_n >= 10'sd255) begin
            norm_res = {sign, 8'hFF, 23'd0};
            norm_flg = 4'b1000;
        end else if (exp_n <= 10'sd0) begin
            norm_res = {sign, 31'd0};
            norm_flg = 4'b0100;
        end else begin
            norm_res = {sign, exp_n[7:0], mant};
            norm_flg = 4'b0000;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        result_d   = result_q;
        flg_d      = flg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (!EN) begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            result_d = 32'd0;
            flg_d    = 4'b0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_d     = A;
                        b_d     = B;
                        busy_d  = 1'b1;
                        state_d = StSpecial;
                    end
                end
                StSpecial: begin
                    spec_d  = 1'b1;
                    state_d = StNorm;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        spec_res_d = DEFAULT_NAN;
                        spec_flg_d = 4'b0010;
                    end else if (a_inf) begin
                        spec_res_d = {sign, 8'hFF, 23'd0};
                        spec_flg_d = 4'b1000;
                    end else if (b_zero) begin
                        spec_res_d = {sign, 8'hFF, 23'd0};
                        spec_flg_d = 4'b1001;
                    end else if (a_zero || b_inf) begin
                        spec_res_d = {sign, 31'd0};
                        spec_flg_d = 4'b0100;
                    end else begin
                        spec_d  = 1'b0;
                        rem_d   = {2'b01, a_q[22:0]};
                        quo_d   = 26'd0;
                        cnt_d   = 5'(N - 1);
                        state_d = StDivide;
                    end
                end
                StDivide: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = StNorm;
                    end
                end
                StNorm: begin
                    result_d = spec_q ? spec_res_q : norm_res;
                    flg_d    = spec_q ? spec_flg_q : norm_flg;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rem_q      <= 25'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            spec_flg_q <= 4'd0;
            result_q   <= 32'd0;
            flg_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            result_q   <= result_d;
            flg_q      <= flg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign infinity    = flg_q[3];
    assign zero        = flg_q[2];
    assign nan         = flg_q[1];
    assign div_by_zero = flg_q[0];

endmodule

// File: tb/tb_floating_division.sv
// Bench for floating_division: two instances (1 and 13 quotient bits per cycle) driven in
// parallel and compared against an integer-arithmetic reference of IEEE single division.
module tb_floating_division;
    logic        clk = 1'b0;
    logic        rst, en, start;
    logic [31:0] a, b;
    logic        busy1, done1, inf1, zero1, nan1, dbz1;
    logic [31:0] res1;
    logic        busy13, done13, inf13, zero13, nan13, dbz13;
    logic [31:0] res13;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FLOAT_DIV_ROUND_NEAREST_EN
    localparam logic [32:0] WantThird = 33'h1_3EAA_AAAB;
`else
    localparam logic [32:0] WantThird = 33'h1_3EAA_AAAA;
`endif

    floating_division #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .EN(en), .start(start), .A(a), .B(b),
        .busy(busy1), .done(done1), .result(res1), .infinity(inf1), .zero(zero1),
        .nan(nan1), .div_by_zero(dbz1)
    );

    floating_division #(.BITS_PER_CYCLE(13)) dut13 (
        .clk(clk), .rst(rst), .EN(en), .start(start), .A(a), .B(b),
        .busy(busy13), .done(done13), .result(res13), .infinity(inf13), .zero(zero13),
        .nan(nan13), .div_by_zero(dbz13)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        special;
        logic        inf;
        logic        zero;
        logic        nan;
        logic        dbz;
        logic [31:0] res;
    } mdl_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic mdl_t ref_div(input logic [31:0] x, input logic [31:0] y);
        mdl_t            r;
        logic            s, xz, xi, xn, yz, yi, yn;
        int              ex, ey, e;
        longint unsigned mx, my, q, rm, mant;
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
        logic            g, st;
`endif
        r  = '0;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yz = (ey == 0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r.special = 1'b1; r.nan = 1'b1; r.res = 32'h7FC0_0000;
        end else if (xi || yz) begin
            r.special = 1'b1; r.inf = 1'b1; r.dbz = !xi; r.res = {s, 8'hFF, 23'd0};
        end else if (xz || yi) begin
            r.special = 1'b1; r.zero = 1'b1; r.res = {s, 31'd0};
        end else begin
            mx = {40'd0, 1'b1, x[22:0]};
            my = {40'd0, 1'b1, y[22:0]};
            q  = (mx << 25) / my;
            rm = (mx << 25) % my;
            e  = ex - ey + 127;
            if (q >= (64'd1 << 25)) begin
                mant = (q >> 2) & 64'h7F_FFFF;
            end else begin
                mant = (q >> 1) & 64'h7F_FFFF;
                e    = e - 1;
            end
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
            if (q >= (64'd1 << 25)) begin
                g  = q[1];
                st = q[0] || (rm != 0);
            end else begin
                g  = q[0];
                st = (rm != 0);
            end
            if (g && (st || mant[0])) mant = mant + 1;
            if (mant == 64'h80_0000) begin
                mant = 0;
                e    = e + 1;
            end
`endif
            if (e >= 255) begin
                r.inf = 1'b1; r.res = {s, 8'hFF, 23'd0};
            end else if (e <= 0) begin
                r.zero = 1'b1; r.res = {s, 31'd0};
            end else begin
                r.res = {s, e[7:0], mant[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 10));
            3:       e = 8'($urandom_range(245, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Issues one operation to both instances; poke_at > 0 fires a second start m cycles later.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [32:0] want,
                          input int poke_at);
        mdl_t        r;
        int          lat1, lat13, nd1;
        logic [31:0] r1, r13;
        logic [3:0]  f1, f13;
        logic        bz1, bz13;
        string       t;
        r = ref_div(xa, xb);
        t = $sformatf("%h/%h", xa, xb);
        lat1 = -1; lat13 = -1; nd1 = 0;
        r1 = '0; r13 = '0; f1 = '0; f13 = '0; bz1 = 1'b1; bz13 = 1'b1;
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({t, " busy1"}, 64'(busy1), 64'd1);
        check_eq({t, " busy13"}, 64'(busy13), 64'd1);
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (done1) begin
                nd1++;
                if (lat1 < 0) begin
                    lat1 = m; r1 = res1; f1 = {inf1, zero1, nan1, dbz1}; bz1 = busy1;
                end
            end
            if (done13 && lat13 < 0) begin
                lat13 = m; r13 = res13; f13 = {inf13, zero13, nan13, dbz13}; bz13 = busy13;
            end
            if (m == poke_at) begin
                a = ~xa; b = xb ^ 32'h0040_0000; start = 1'b1;
            end
        end
        check_eq({t, " result1"}, 64'(r1), 64'(r.res));
        check_eq({t, " flags1"}, 64'(f1), 64'({r.inf, r.zero, r.nan, r.dbz}));
        check_eq({t, " latency1"}, 64'(lat1), 64'(r.special ? 2 : 28));
        check_eq({t, " done_count1"}, 64'(nd1), 64'd1);
        check_eq({t, " busy_at_done1"}, 64'(bz1), 64'd0);
        check_eq({t, " result13"}, 64'(r13), 64'(r.res));
        check_eq({t, " flags13"}, 64'(f13), 64'({r.inf, r.zero, r.nan, r.dbz}));
        check_eq({t, " latency13"}, 64'(lat13), 64'(r.special ? 2 : 4));
        check_eq({t, " busy_at_done13"}, 64'(bz13), 64'd0);
        if (want[32]) begin
            check_eq({t, " known1"}, 64'(r1), 64'(want[31:0]));
            check_eq({t, " known13"}, 64'(r13), 64'(want[31:0]));
        end
    endtask

    // Starts 6.0/2.0 and kills it at cycle 10 with rst (use_rst=1) or by dropping EN.
    task automatic abort_op(input bit use_rst);
        int    nd;
        string t;
        t = use_rst ? "rst_abort" : "en_abort";
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        if (use_rst) begin
            rst = 1'b1;
            #1;
            check_eq({t, " busy1"}, 64'(busy1), 64'd0);
            check_eq({t, " result1"}, 64'(res1), 64'd0);
            check_eq({t, " done1"}, 64'(done1), 64'd0);
            check_eq({t, " result13"}, 64'(res13), 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            en = 1'b0; start = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
            @(negedge clk);
            check_eq({t, " busy1"}, 64'(busy1), 64'd0);
            check_eq({t, " result1"}, 64'(res1), 64'd0);
            check_eq({t, " done1"}, 64'(done1), 64'd0);
            check_eq({t, " busy13_start_ignored"}, 64'(busy13), 64'd0);
            check_eq({t, " result13"}, 64'(res13), 64'd0);
            start = 1'b0;
            @(negedge clk);
            en = 1'b1;
        end
        nd = 0;
        repeat (35) begin
            @(negedge clk);
            if (done1 || done13) nd++;
        end
        check_eq({t, " no_done"}, 64'(nd), 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset result1", 64'(res1), 64'd0);
        check_eq("reset busy1", 64'(busy1), 64'd0);
        check_eq("reset done1", 64'(done1), 64'd0);
        check_eq("reset flags1", 64'({inf1, zero1, nan1, dbz1}), 64'd0);
        check_eq("reset result13", 64'(res13), 64'd0);
        check_eq("reset busy13", 64'(busy13), 64'd0);
        rst = 1'b0;

        run_op(32'h40C0_0000, 32'h4000_0000, 33'h1_4040_0000, 0);
        run_op(32'h3F80_0000, 32'h4040_0000, WantThird, 0);
        run_op(32'hC100_0000, 32'h3F00_0000, 33'h1_C180_0000, 0);
        run_op(32'h3F80_0000, 32'h0000_0000, 33'h1_7F80_0000, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 33'h1_7FC0_0000, 0);
        run_op(32'h7F00_0000, 32'h0080_0000, 33'h1_7F80_0000, 0);
        run_op(32'h40C0_0000, 32'h4000_0000, 33'h1_4040_0000, 5);
        abort_op(1'b1);
        run_op(32'h40C0_0000, 32'h4000_0000, 33'h1_4040_0000, 0);
        abort_op(1'b0);

        for (int i = 0; i < 50; i++) begin
            run_op(rand_fp(), rand_fp(), 33'd0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
